if_fetch_unit: RTL and testbench

Instruction-fetch front end of the 5-stage MIPS pipeline: owns the PC, fetches from a variable-latency instruction memory over a req/ack handshake, and drives the IF/ID pipeline register. It is the producer side of the ID-stage interface:
- consumes the ID hazard stall (freeze);
- consumes the EXE branch redirect (flush);
- supplies Instruction and PC+4 to ID.

A one-entry skid buffer absorbs a fetch that returns while ID is frozen.

---
 rtl/if_fetch_unit.sv | 206 ++++++++++++++++++++
 tb/tb_if_fetch_unit.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// if_fetch_unit
// Instruction-fetch front end of the 5-stage MIPS pipeline. Owns the PC,
// fetches over a req/ack handshake to a variable-latency instruction memory,
// and drives the IF/ID pipeline register. A one-entry skid buffer holds a
// word that returns while ID is frozen. A branch redirect issued while a
// request is outstanding leaves the FSM in DROP, where the stale response
// is absorbed before the new target is fetched.

module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Freeze,
  input  logic        Br_taken,
  input  logic [31:0] Br_Addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        IF_Valid,
  output logic [31:0] IF_Instruction,
  output logic [31:0] IF_PC
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  // Fetch-side state
  logic [1:0]  state_r;
  logic [1:0]  state_s;
  logic [31:0] pc_r;
  logic [31:0] pc_s;
  logic [31:0] addr_r;
  logic [31:0] addr_s;
  logic        req_r;
  logic        req_s;
  logic        deliver_s;
  logic [31:0] pc_inc_s;
  logic [31:0] br_target_s;

  // Skid buffer
  logic        buf_valid_r;
  logic        buf_valid_s;
  logic [31:0] buf_instr_r;
  logic [31:0] buf_instr_s;
  logic [31:0] buf_pc_r;
  logic [31:0] buf_pc_s;

  // IF/ID register
  logic        if_valid_r;
  logic        if_valid_s;
  logic [31:0] if_instr_r;
  logic [31:0] if_instr_s;
  logic [31:0] if_pc_r;
  logic [31:0] if_pc_s;

  // Redirect target is word-aligned; sequential PC wraps naturally mod 2^32.
  assign br_target_s = Br_Addr & 32'hFFFF_FFFC;
  assign pc_inc_s    = pc_r + 32'd4;

  // Next-state logic for the fetch FSM, PC and outstanding request address.
  always_comb begin
    state_s   = state_r;
    pc_s      = pc_r;
    addr_s    = addr_r;
    deliver_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (Br_taken) begin
          pc_s = br_target_s;
        end else begin
          pc_s = pc_r;
        end
        // A full buffer blocks new requests; the late-ack of an abandoned
        // request is simply not looked at here.
        if (!buf_valid_r) begin
          state_s = ST_WAIT;
          addr_s  = pc_s;
        end else begin
          state_s = ST_IDLE;
          addr_s  = addr_r;
        end
      end
      ST_WAIT: begin
        if (Br_taken) begin
          pc_s = br_target_s;
          if (imem_ack) begin
            // Response retires with the redirect; nothing is left in flight.
            state_s = ST_WAIT;
            addr_s  = br_target_s;
          end else begin
            // Request still in flight: keep presenting it and discard later.
            state_s = ST_DROP;
            addr_s  = addr_r;
          end
        end else if (imem_ack) begin
          deliver_s = 1'b1;
          pc_s      = pc_inc_s;
          if (Freeze) begin
            state_s = ST_IDLE;
            addr_s  = addr_r;
          end else begin
            state_s = ST_WAIT;
            addr_s  = pc_inc_s;
          end
        end else begin
          state_s = ST_WAIT;
          pc_s    = pc_r;
          addr_s  = addr_r;
        end
      end
      ST_DROP: begin
        if (Br_taken) begin
          pc_s = br_target_s;
        end else begin
          pc_s = pc_r;
        end
        if (imem_ack) begin
          state_s = ST_WAIT;
          addr_s  = pc_s;
        end else begin
          state_s = ST_DROP;
          addr_s  = addr_r;
        end
      end
      default: begin
        state_s = ST_IDLE;
        pc_s    = pc_r;
        addr_s  = addr_r;
      end
    endcase
  end

  assign req_s = (state_s != ST_IDLE);

  // IF/ID and skid-buffer update: flush, then freeze, then buffer, then fetch.
  always_comb begin
    if_valid_s  = if_valid_r;
    if_instr_s  = if_instr_r;
    if_pc_s     = if_pc_r;
    buf_valid_s = buf_valid_r;
    buf_instr_s = buf_instr_r;
    buf_pc_s    = buf_pc_r;
    if (Br_taken) begin
      if_valid_s  = 1'b0;
      if_instr_s  = 32'h0000_0000;
      buf_valid_s = 1'b0;
    end else if (Freeze) begin
      if (deliver_s) begin
        buf_valid_s = 1'b1;
        buf_instr_s = imem_rdata;
        buf_pc_s    = pc_inc_s;
      end else begin
        buf_valid_s = buf_valid_r;
      end
    end else if (buf_valid_r) begin
      if_valid_s  = 1'b1;
      if_instr_s  = buf_instr_r;
      if_pc_s     = buf_pc_r;
      buf_valid_s = 1'b0;
    end else if (deliver_s) begin
      if_valid_s = 1'b1;
      if_instr_s = imem_rdata;
      if_pc_s    = pc_inc_s;
    end else begin
      if_valid_s = 1'b0;
      if_instr_s = 32'h0000_0000;
    end
  end

  // State, request and pipeline registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      pc_r        <= RESET_PC;
      addr_r      <= RESET_PC;
      req_r       <= 1'b0;
      buf_valid_r <= 1'b0;
      buf_instr_r <= 32'h0000_0000;
      buf_pc_r    <= 32'h0000_0000;
      if_valid_r  <= 1'b0;
      if_instr_r  <= 32'h0000_0000;
      if_pc_r     <= 32'h0000_0000;
    end else begin
      state_r     <= state_s;
      pc_r        <= pc_s;
      addr_r      <= addr_s;
      req_r       <= req_s;
      buf_valid_r <= buf_valid_s;
      buf_instr_r <= buf_instr_s;
      buf_pc_r    <= buf_pc_s;
      if_valid_r  <= if_valid_s;
      if_instr_r  <= if_instr_s;
      if_pc_r     <= if_pc_s;
    end
  end

  assign imem_req       = req_r;
  assign imem_addr      = addr_r;
  assign IF_Valid       = if_valid_r;
  assign IF_Instruction = if_instr_r;
  assign IF_PC          = if_pc_r;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: transaction-level reference model (one
// outstanding request record, a buffer queue, an IF/ID record), a
// memory responder with fixed or random latency, directed scenarios with
// literal expectations, and a randomized run.

module tb_if_fetch_unit;

  localparam logic [31:0] PAT = 32'hA5A5_0000;

  logic        clk;
  logic        rst;
  logic        Freeze;
  logic        Br_taken;
  logic [31:0] Br_Addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        IF_Valid;
  logic [31:0] IF_Instruction;
  logic [31:0] IF_PC;

  int errors = 0;
  int checks = 0;

  if_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .Freeze(Freeze), .Br_taken(Br_taken), .Br_Addr(Br_Addr),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .IF_Valid(IF_Valid), .IF_Instruction(IF_Instruction), .IF_PC(IF_PC)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic        m_req;      // a request is outstanding
  logic [31:0] m_addr;     // its address
  logic        m_stale;    // its response must be thrown away
  logic [31:0] m_pc;       // next sequential fetch address
  logic [63:0] m_bq[$];    // skid buffer contents {instr, pc+4}
  logic        m_vld;
  logic [31:0] m_ins;
  logic [31:0] m_ifpc;
  logic        m_dlv, m_done, m_idle, m_bhad;
  logic [31:0] m_dins, m_dpc, m_tgt, m_npc;
  logic [63:0] m_e;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_req = 1'b0; m_addr = 32'h0; m_stale = 1'b0; m_pc = 32'h0;
      m_bq.delete();
      m_vld = 1'b0; m_ins = 32'h0; m_ifpc = 32'h0;
    end else begin
      m_tgt  = Br_Addr & 32'hFFFF_FFFC;
      m_idle = !m_req;
      m_bhad = (m_bq.size() != 0);
      m_dlv  = 1'b0;
      m_done = 1'b0;
      m_dins = 32'h0;
      m_dpc  = 32'h0;
      if (m_req && imem_ack) begin
        m_done = 1'b1;
        if (!m_stale && !Br_taken) begin
          m_dlv  = 1'b1;
          m_dins = imem_rdata;
          m_dpc  = m_addr + 32'd4;
        end
      end
      m_npc = Br_taken ? m_tgt : (m_dlv ? m_addr + 32'd4 : m_pc);
      // pipeline register / buffer, in priority order
      if (Br_taken) begin
        m_vld = 1'b0; m_ins = 32'h0; m_bq.delete();
      end else if (Freeze) begin
        if (m_dlv) m_bq.push_back({m_dins, m_dpc});
      end else if (m_bq.size() != 0) begin
        m_e = m_bq.pop_front();
        m_vld = 1'b1; m_ins = m_e[63:32]; m_ifpc = m_e[31:0];
      end else if (m_dlv) begin
        m_vld = 1'b1; m_ins = m_dins; m_ifpc = m_dpc;
      end else begin
        m_vld = 1'b0; m_ins = 32'h0;
      end
      // request bookkeeping: at most one in flight, none while buffer full
      if (m_idle) begin
        if (!m_bhad) begin m_req = 1'b1; m_addr = m_npc; m_stale = 1'b0; end
      end else if (m_done) begin
        if (m_dlv && Freeze) m_req = 1'b0;
        else begin m_req = 1'b1; m_addr = m_npc; m_stale = 1'b0; end
      end else begin
        m_stale = m_stale | Br_taken;
      end
      m_pc = m_npc;
    end
  end

  // Every-cycle comparison against the model, on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      chk("if_valid", {31'd0, IF_Valid}, {31'd0, m_vld});
      chk("if_instr", IF_Instruction, m_ins);
      if (m_vld) chk("if_pc", IF_PC, m_ifpc);
      chk("imem_req", {31'd0, imem_req}, {31'd0, m_req});
      if (m_req) chk("imem_addr", imem_addr, m_addr);
    end
  end

  // ---------------- memory responder ----------------
  int mem_lat  = 0;
  bit mem_rand = 1'b0;
  int lat_cur  = 0;
  int cnt      = 0;

  initial begin
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      #1;
      if (rst || !m_req) begin
        imem_ack   = mem_rand && !rst && ($urandom_range(0, 3) == 0);
        imem_rdata = $urandom;
        cnt        = 0;
        lat_cur    = mem_rand ? int'($urandom_range(0, 3)) : mem_lat;
      end else if (cnt >= lat_cur) begin
        imem_ack   = 1'b1;
        imem_rdata = mem_rand ? $urandom : (m_addr ^ PAT);
        cnt        = 0;
        lat_cur    = mem_rand ? int'($urandom_range(0, 3)) : mem_lat;
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        cnt++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic do_reset();
    @(negedge clk);
    #1;
    rst = 1'b1; Freeze = 1'b0; Br_taken = 1'b0; Br_Addr = 32'h0;
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_req(input logic [31:0] a, input bit need_ack, input string nm);
    bit found = 1'b0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      #2;
      if (imem_req && imem_addr == a && (!need_ack || imem_ack)) begin
        found = 1'b1;
        break;
      end
    end
    chk(nm, {31'd0, found}, 32'd1);
  endtask

  task automatic wait_valid(input logic [31:0] exp_pc, input string nm);
    bit found = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (IF_Valid) begin
        found = 1'b1;
        break;
      end
    end
    chk({nm, "_seen"}, {31'd0, found}, 32'd1);
    chk({nm, "_pc"}, IF_PC, exp_pc);
    chk({nm, "_instr"}, IF_Instruction, (exp_pc - 32'd4) ^ PAT);
  endtask

  int  vcount;
  bit  did_rst;
  logic [31:0] exp_word;

  initial begin
    rst = 1'b1; Freeze = 1'b0; Br_taken = 1'b0; Br_Addr = 32'h0;

    // Reset values
    #12;
    chk("rst_valid", {31'd0, IF_Valid}, 32'd0);
    chk("rst_instr", IF_Instruction, 32'd0);
    chk("rst_ifpc", IF_PC, 32'd0);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'd0);

    // Zero-wait memory: back-to-back fetches from address 0
    mem_lat = 0;
    do_reset();
    chk("idle_after_rst", {31'd0, imem_req}, 32'd0);
    @(posedge clk); #1;
    chk("first_req", {31'd0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      exp_word = 32'(4 * i) ^ PAT;
      chk("zw_valid", {31'd0, IF_Valid}, 32'd1);
      chk("zw_pc", IF_PC, 32'(4 * (i + 1)));
      chk("zw_instr", IF_Instruction, exp_word);
    end

    // 3-cycle latency: one valid word every 4 cycles
    mem_lat = 3;
    do_reset();
    @(posedge clk); #1;
    vcount = 0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      if (IF_Valid) vcount++;
    end
    chk("lat3_pulses", 32'(vcount), 32'd4);

    // Freeze for 5 cycles while the fetch of 0x10 completes
    mem_lat = 0;
    do_reset();
    wait_req(32'h10, 1'b0, "wait_0x10");
    Freeze = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("frz_valid", {31'd0, IF_Valid}, 32'd1);
      chk("frz_pc", IF_PC, 32'h10);
      chk("frz_instr", IF_Instruction, 32'h0C ^ PAT);
      chk("frz_req", {31'd0, imem_req}, 32'd0);
      if (i == 4) Freeze = 1'b0;
    end
    @(posedge clk); #1;
    chk("rel_pc", IF_PC, 32'h14);
    chk("rel_instr", IF_Instruction, 32'h10 ^ PAT);
    @(posedge clk); #1;
    chk("rel_bubble", {31'd0, IF_Valid}, 32'd0);
    chk("rel_req_addr", imem_addr, 32'h14);
    @(posedge clk); #1;
    chk("rel_next_pc", IF_PC, 32'h18);

    // Branch while 0x20 is pending (DROP path)
    mem_lat = 2;
    do_reset();
    wait_req(32'h20, 1'b0, "wait_0x20");
    Br_taken = 1'b1; Br_Addr = 32'h100;
    @(posedge clk); #1;
    Br_taken = 1'b0;
    chk("drop_flush", {31'd0, IF_Valid}, 32'd0);
    chk("drop_addr", imem_addr, 32'h20);
    wait_valid(32'h104, "drop_first");

    // Branch together with Freeze and a full buffer
    mem_lat = 0;
    do_reset();
    wait_req(32'h10, 1'b0, "wait_0x10b");
    Freeze = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    Br_taken = 1'b1; Br_Addr = 32'h303;
    @(posedge clk); #1;
    chk("bf_valid", {31'd0, IF_Valid}, 32'd0);
    chk("bf_instr", IF_Instruction, 32'd0);
    chk("bf_req", {31'd0, imem_req}, 32'd0);
    Br_taken = 1'b0; Freeze = 1'b0;
    @(posedge clk); #1;
    chk("bf_no_reload", {31'd0, IF_Valid}, 32'd0);
    chk("bf_req2", {31'd0, imem_req}, 32'd1);
    chk("bf_addr", imem_addr, 32'h300);
    @(posedge clk); #1;
    chk("bf_pc", IF_PC, 32'h304);

    // Branch on an ack, then redirect again, then a branch inside DROP
    mem_lat = 2;
    do_reset();
    wait_req(32'h20, 1'b1, "wait_ack_0x20");
    Br_taken = 1'b1; Br_Addr = 32'h180;
    @(posedge clk); #1;
    Br_Addr = 32'h1C0;
    @(posedge clk); #1;
    Br_Addr = 32'h200;
    @(posedge clk); #1;
    Br_taken = 1'b0;
    chk("dd_addr", imem_addr, 32'h180);
    wait_valid(32'h204, "dd_first");

    // Randomized run with random latency and spurious acks
    mem_rand = 1'b1;
    do_reset();
    did_rst = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk); #1;
      Freeze   = ($urandom_range(0, 3) == 0);
      Br_taken = ($urandom_range(0, 11) == 0);
      Br_Addr  = $urandom;
      if ($urandom_range(0, 3) == 0) Br_Addr = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      if (!did_rst && i >= 1500 && imem_req) begin
        rst = 1'b1;
        #1;
        chk("midrst_req", {31'd0, imem_req}, 32'd0);
        chk("midrst_valid", {31'd0, IF_Valid}, 32'd0);
        chk("midrst_addr", imem_addr, 32'd0);
        @(negedge clk); #1;
        rst = 1'b0;
        did_rst = 1'b1;
      end
    end
    Freeze = 1'b0; Br_taken = 1'b0;
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
